// File: rtl/data_memory_if.sv
// data_memory_if
//   Bus between the data cache controller (master) and the word-organised
//   backing store (slave). Groups the request, data and handshake signals so
//   both ends see one consistent bundle.
//
//   read      : read request (block fill)
//   write     : write request (write-back)
//   address   : 6-bit word address
//   writedata : 32-bit word to store
//   readdata  : registered 32-bit read result
//   busywait  : high while a request is pending or in progress
//
//   Modports:
//     master : the cache side, drives requests and observes the handshake
//     slave  : the memory side, receives requests and returns data/handshake
interface data_memory_if;
  logic        read;
  logic        write;
  logic [5:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        busywait;

  modport master (
    output read,
    output write,
    output address,
    output writedata,
    input  readdata,
    input  busywait
  );

  modport slave (
    input  read,
    input  write,
    input  address,
    input  writedata,
    output readdata,
    output busywait
  );
endinterface

// File: rtl/data_memory.sv
// data_memory
//   Word-organised backing store downstream of the data cache. Holds DEPTH
//   words of 32 bits and serves block fills (reads) and write-backs (writes)
//   with a fixed access latency. Completion is signalled by busywait falling
//   for exactly one cycle (DONE) before the store becomes idle again, so the
//   cache always observes busywait low before it can issue its next request.
//
//   Parameters:
//     LATENCY : posedges from request acceptance to access commit (1..15)
//     DEPTH   : number of 32-bit words, must be 64 to match the 6-bit address
//
//   Ports:
//     clock   : single clock, all state changes on posedge
//     reset   : synchronous, active-low reset
//     mem_bus : data_memory_if.slave (read, write, address, writedata in;
//               readdata, busywait out)
//
//   Build option:
//     DATA_MEMORY_CLEAR_ON_RESET_EN : when defined, every reset posedge also
//     clears all words to zero; when undefined, reset leaves the storage
//     untouched.
module data_memory #(
  parameter int LATENCY = 5,
  parameter int DEPTH   = 64
) (
  input logic          clock,
  input logic          reset,
  data_memory_if.slave mem_bus
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  // The counter is loaded with LATENCY-1 so that the commit lands exactly
  // LATENCY posedges after the accepting edge.
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t      state;
  state_t      next_state;
  logic [3:0]  cnt;
  logic [5:0]  addr_q;
  logic [31:0] wdata_q;
  logic        op_write_q;
  logic [31:0] readdata_q;
  logic        busy;
  logic        request;
  logic        commit;

  logic [31:0] mem [0:DEPTH-1];

  assign request = mem_bus.read | mem_bus.write;
  assign commit  = (state == BUSY) && (cnt == 4'd0);

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake decode. busywait follows the request
  // combinationally in IDLE so the cache sees it in the same cycle it asks.
  // DONE unconditionally returns to IDLE, ignoring any request present, and
  // reset overrides everything so the cache never stalls on a held request.
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        busy = request;
        if (request) begin
          next_state = BUSY;
        end
      end
      BUSY: begin
        busy = 1'b1;
        if (cnt == 4'd0) begin
          next_state = DONE;
        end
      end
      DONE: begin
        busy       = 1'b0;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    if (!reset) begin
      busy = 1'b0;
    end
  end

  // Request capture, latency counter and read result. Once accepted, only
  // the latched address/data/op are used, so the cache may change its
  // outputs freely while the access is in flight. When both read and write
  // are requested the write wins. readdata only changes on a read commit.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt        <= 4'd0;
      addr_q     <= 6'd0;
      wdata_q    <= 32'd0;
      op_write_q <= 1'b0;
      readdata_q <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (request) begin
            addr_q     <= mem_bus.address;
            wdata_q    <= mem_bus.writedata;
            op_write_q <= mem_bus.write;
            cnt        <= CNT_INIT;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (!op_write_q) begin
            readdata_q <= mem[addr_q];
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef DATA_MEMORY_CLEAR_ON_RESET_EN
  // Storage with clear-on-reset. A reset during BUSY wipes the array and
  // the pending write is dropped along with everything else.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 32'd0;
      end
    end else if (commit && op_write_q) begin
      mem[addr_q] <= wdata_q;
    end
  end
`else
  // Storage that survives reset. The commit is still gated by reset so an
  // access aborted by reset never reaches the array.
  always_ff @(posedge clock) begin
    if (reset && commit && op_write_q) begin
      mem[addr_q] <= wdata_q;
    end
  end
`endif

  assign mem_bus.busywait = busy;
  assign mem_bus.readdata = readdata_q;

endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory
//   Directed bench for data_memory. Two instances are built side by side,
//   one with LATENCY=5 and one with LATENCY=1, each on its own interface
//   and sharing clock and reset. A table of transactions is run on the
//   LATENCY=5 instance, followed by hand-written sequences for readdata
//   hold, back-to-back write-back/fill on both latencies and reset in the
//   middle of an access.
module tb_data_memory;

  logic clock;
  logic reset;

  int checkCount;
  int passCount;

  data_memory_if bus5 ();
  data_memory_if bus1 ();

  data_memory #(.LATENCY(5), .DEPTH(64)) dut5 (
    .clock   (clock),
    .reset   (reset),
    .mem_bus (bus5.slave)
  );

  data_memory #(.LATENCY(1), .DEPTH(64)) dut1 (
    .clock   (clock),
    .reset   (reset),
    .mem_bus (bus1.slave)
  );

  // 10-unit clock period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [31:0] expRead;
  } vec_t;

  vec_t vecs [12];

  // Drives the request signals of the selected instance (sel=1 -> LATENCY=1).
  task automatic applyStimulus(input bit sel, input logic rd, input logic wr,
                               input logic [5:0] addr, input logic [31:0] data);
    if (sel) begin
      bus1.read      = rd;
      bus1.write     = wr;
      bus1.address   = addr;
      bus1.writedata = data;
    end else begin
      bus5.read      = rd;
      bus5.write     = wr;
      bus5.address   = addr;
      bus5.writedata = data;
    end
  endtask

  function automatic logic getBusy(input bit sel);
    return sel ? bus1.busywait : bus5.busywait;
  endfunction

  function automatic logic [31:0] getRead(input bit sel);
    return sel ? bus1.readdata : bus5.readdata;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic checkNotEqual(input string name, input logic [31:0] actual,
                               input logic [31:0] forbidden);
    checkCount++;
    if (actual !== forbidden) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h, must differ from %h", name, actual, forbidden);
    end
  endtask

  // One complete access, entered and left one time unit after a posedge
  // with the store idle. The request is dropped right after acceptance and
  // address/data are scrambled so only latched values can be used. busywait
  // is checked every cycle; readdata is returned as seen in DONE.
  task automatic runAccess(input bit sel, input logic rd, input logic wr,
                           input logic [5:0] addr, input logic [31:0] data,
                           input int lat, input string tag,
                           output logic [31:0] rdOut);
    applyStimulus(sel, rd, wr, addr, data);
    #1;
    checkOutput({tag, "_busy_req"}, 32'(getBusy(sel)), 32'd1);
    @(posedge clock);
    #1;
    applyStimulus(sel, 1'b0, 1'b0, addr + 6'd1, ~data);
    checkOutput({tag, "_busy_e0"}, 32'(getBusy(sel)), 32'd1);
    for (int k = 1; k < lat; k++) begin
      @(posedge clock);
      #1;
      checkOutput($sformatf("%s_busy_e%0d", tag, k), 32'(getBusy(sel)), 32'd1);
    end
    @(posedge clock);
    #1;
    checkOutput({tag, "_done_low"}, 32'(getBusy(sel)), 32'd0);
    rdOut = getRead(sel);
    @(posedge clock);
    #1;
  endtask

  // Write-back immediately followed by a fill whose request is already
  // raised in DONE. DONE must ignore it, IDLE must accept it one edge
  // later (E0+LATENCY+2), and the fill must return the word just written.
  task automatic backToBack(input bit sel, input int lat,
                            input logic [5:0] addr, input logic [31:0] data,
                            input string tag);
    applyStimulus(sel, 1'b0, 1'b1, addr, data);
    #1;
    checkOutput({tag, "_wr_busy_req"}, 32'(getBusy(sel)), 32'd1);
    @(posedge clock);
    #1;
    applyStimulus(sel, 1'b0, 1'b0, addr, 32'd0);
    checkOutput({tag, "_wr_busy_e0"}, 32'(getBusy(sel)), 32'd1);
    for (int k = 1; k < lat; k++) begin
      @(posedge clock);
      #1;
      checkOutput($sformatf("%s_wr_busy_e%0d", tag, k), 32'(getBusy(sel)), 32'd1);
    end
    @(posedge clock);
    #1;
    applyStimulus(sel, 1'b1, 1'b0, addr, 32'd0);
    #1;
    checkOutput({tag, "_done_ignores_req"}, 32'(getBusy(sel)), 32'd0);
    @(posedge clock);
    #1;
    checkOutput({tag, "_idle_sees_req"}, 32'(getBusy(sel)), 32'd1);
    @(posedge clock);
    #1;
    applyStimulus(sel, 1'b0, 1'b0, addr, 32'd0);
    checkOutput({tag, "_rd_busy_e0"}, 32'(getBusy(sel)), 32'd1);
    for (int k = 1; k < lat; k++) begin
      @(posedge clock);
      #1;
      checkOutput($sformatf("%s_rd_busy_e%0d", tag, k), 32'(getBusy(sel)), 32'd1);
    end
    @(posedge clock);
    #1;
    checkOutput({tag, "_rd_done_low"}, 32'(getBusy(sel)), 32'd0);
    checkOutput({tag, "_rd_data"}, getRead(sel), data);
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [31:0] rdOut;

    checkCount = 0;
    passCount  = 0;

    // Transaction table for the LATENCY=5 instance. expRead is readdata as
    // seen in DONE: the read word for reads, the held previous value for
    // writes. Entry 2 requests read and write together (write wins), entry
    // 6 reads word 1 while the scrambled address points at word 2.
    vecs[0]  = '{1'b0, 1'b1, 6'd12, 32'hDEADBEEF, 32'h00000000};
    vecs[1]  = '{1'b1, 1'b0, 6'd12, 32'h00000000, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 1'b1, 6'd3,  32'h12345678, 32'hDEADBEEF};
    vecs[3]  = '{1'b1, 1'b0, 6'd3,  32'h00000000, 32'h12345678};
    vecs[4]  = '{1'b0, 1'b1, 6'd1,  32'h11111111, 32'h12345678};
    vecs[5]  = '{1'b0, 1'b1, 6'd2,  32'h22222222, 32'h12345678};
    vecs[6]  = '{1'b1, 1'b0, 6'd1,  32'h00000000, 32'h11111111};
    vecs[7]  = '{1'b1, 1'b0, 6'd2,  32'h00000000, 32'h22222222};
    vecs[8]  = '{1'b0, 1'b1, 6'd63, 32'hCAFEF00D, 32'h22222222};
    vecs[9]  = '{1'b0, 1'b1, 6'd0,  32'h0BADC0DE, 32'h22222222};
    vecs[10] = '{1'b1, 1'b0, 6'd63, 32'h00000000, 32'hCAFEF00D};
    vecs[11] = '{1'b1, 1'b0, 6'd0,  32'h00000000, 32'h0BADC0DE};

    // Reset with a write held on both instances: busywait must stay low.
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 6'd5, 32'h55555555);
    applyStimulus(1'b1, 1'b0, 1'b1, 6'd5, 32'h55555555);
    repeat (2) @(posedge clock);
    #1;
    checkOutput("rst_busy_l5", 32'(getBusy(1'b0)), 32'd0);
    checkOutput("rst_busy_l1", 32'(getBusy(1'b1)), 32'd0);
    checkOutput("rst_readdata_l5", getRead(1'b0), 32'd0);
    checkOutput("rst_readdata_l1", getRead(1'b1), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 6'd0, 32'd0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("idle_busy_l5", 32'(getBusy(1'b0)), 32'd0);

    for (int i = 0; i < 12; i++) begin
      runAccess(1'b0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, 5,
                $sformatf("vec%0d", i), rdOut);
      checkOutput($sformatf("vec%0d_readdata", i), rdOut, vecs[i].expRead);
    end

    // readdata must hold across idle cycles after the last read.
    for (int k = 0; k < 3; k++) begin
      @(posedge clock);
      #1;
      checkOutput($sformatf("hold_readdata_%0d", k), getRead(1'b0), 32'h0BADC0DE);
      checkOutput($sformatf("hold_busy_%0d", k), 32'(getBusy(1'b0)), 32'd0);
    end

    backToBack(1'b0, 5, 6'd20, 32'h5A5A1234, "b2b_l5");
    backToBack(1'b1, 1, 6'd40, 32'h13579BDF, "b2b_l1");
    backToBack(1'b1, 1, 6'd63, 32'hF00DFACE, "b2b_l1_top");

    // Reset during BUSY of a write to word 7 (asserted for edges E2, E3).
    applyStimulus(1'b0, 1'b0, 1'b1, 6'd7, 32'hAAAA5555);
    @(posedge clock);
    #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd7, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 6'd7, 32'hAAAA5555);
    #1;
    checkOutput("midrst_busy_comb", 32'(getBusy(1'b0)), 32'd0);
    @(posedge clock);
    #1;
    checkOutput("midrst_busy_e2", 32'(getBusy(1'b0)), 32'd0);
    checkOutput("midrst_readdata", getRead(1'b0), 32'd0);
    @(posedge clock);
    #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
    reset = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    checkOutput("postrst_busy", 32'(getBusy(1'b0)), 32'd0);
    checkOutput("postrst_readdata", getRead(1'b0), 32'd0);
    runAccess(1'b0, 1'b1, 1'b0, 6'd7, 32'd0, 5, "rd7", rdOut);
    checkNotEqual("rd7_not_aborted_data", rdOut, 32'hAAAA5555);
`ifdef DATA_MEMORY_CLEAR_ON_RESET_EN
    checkOutput("rd7_cleared", rdOut, 32'd0);
    runAccess(1'b0, 1'b1, 1'b0, 6'd12, 32'd0, 5, "rd12", rdOut);
    checkOutput("rd12_cleared", rdOut, 32'd0);
`else
    runAccess(1'b0, 1'b1, 1'b0, 6'd12, 32'd0, 5, "rd12", rdOut);
    checkOutput("rd12_retained", rdOut, 32'hDEADBEEF);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/data_memory.md
# data_memory

Word-organised backing store that sits directly downstream of the data cache and serves its block fill and write-back requests. It holds 64 words of 32 bits, addressed by the cache's 6-bit memory address. Each access has a fixed, parameterised latency. The block signals completion by dropping `busywait`, the handshake the cache controller FSM polls in its MEM_READ and MEM_WRITE states.

## Interface
- `LATENCY`, default 5: posedges from request acceptance to access commit; legal range 1..15.
- `DEPTH`, default 64: number of 32-bit words; must equal 2^6.
- `clock` in 1: single clock; all state changes on posedge.
- `reset` in 1: reset is synchronous and active-low, sampled on `clock` posedge.
- `read` in 1: read request (cache `mem_read`).
- `write` in 1: write request (cache `mem_write`).
- `address` in 6: word address (cache `mem_address`).
- `writedata` in 32: write data (cache `mem_writedata`).
- `readdata` out 32: registered read result (to cache `mem_readdata`).
- `busywait` out 1: high while a request is pending or in progress (to cache `mem_busywait`).

## Operation
- Storage: `mem[0:63]` of 32 bits, indexed by `address`.
- FSM states are IDLE, BUSY and DONE. A 4-bit down-counter `cnt` times the access.
- IDLE:
  - `busywait = read | write`, combinational, so it is high in the same cycle the request appears.
  - On a posedge with `read | write`: latch `address`, `writedata` and the op, set `cnt = LATENCY-1`, go to BUSY.
  - If both `read` and `write` are high, the write wins; the read is dropped.
- BUSY:
  - `busywait = 1`.
  - On a posedge with `cnt != 0`: decrement `cnt`.
  - On a posedge with `cnt == 0`, commit the access and go to DONE:
    - Write: `mem[addr_q] <= wdata_q`; `readdata` is unchanged.
    - Read: `readdata <= mem[addr_q]`.
- DONE:
  - `busywait = 0`.
  - The next posedge always returns to IDLE, and any request present at that edge is ignored.
  - This guarantees the cache sees `busywait` low before it issues a new request.
- Inputs that change during BUSY are ignored; only the latched values are used.
- `readdata` holds its value until the next read commit, so the cache may sample it late in CACHE_UPDATE.
- Reset (`reset == 0` at posedge):
  - State goes to IDLE, `cnt = 0`, `readdata = 32'd0`.
  - `busywait` is forced to 0 while `reset` is low, regardless of `read`/`write`.
  - A reset during BUSY aborts the access: no write commit, no `readdata` update.
  - `mem` contents are handled per Configuration.

## Timing
- Request sampled at edge E0. Commit at edge E0+LATENCY. `busywait` falls just after E0+LATENCY. Back in IDLE at E0+LATENCY+1.
- With LATENCY=5, `busywait` is high from the request's arrival through E5, and is low in the E5–E6 cycle.
- With LATENCY=1, commit happens at E1.
- Back-to-back requests: the earliest next acceptance is E0+LATENCY+2 (first IDLE posedge).
- Write-back followed by fill (cache MEM_WRITE→MEM_READ) takes 2×(LATENCY+2) cycles minimum.
- No combinational path from `address`/`writedata` to any output. The only combinational path is from `read`/`write` to `busywait`, and only in IDLE.

## Configuration
- `DATA_MEMORY_CLEAR_ON_RESET_EN`:
  - Defined: every reset posedge also clears all 64 words to `32'd0` in that same cycle.
  - Undefined: reset leaves `mem` untouched; power-up contents are X in simulation.
  - Both builds: `readdata`, FSM and `cnt` reset as above.

## Test plan
- Reset, then write 0xDEADBEEF to address 6'd12 with LATENCY=5: `busywait` is high the same cycle as `write` and stays high through E5, is low at E5+, and the FSM is in IDLE at E6.
- Read address 6'd12 after the above: `readdata` is 0xDEADBEEF after E5 and holds that value after `read` deasserts, through at least 3 idle cycles.
- Assert `read` and `write` together on address 6'd3 with data 0x12345678: a write is performed, and a later read of 6'd3 returns 0x12345678 while `readdata` is unchanged during the write.
- Write 0xAAAA5555 to 6'd7, then apply reset at E2 (mid-BUSY): `busywait` is 0 during reset. A later read of 6'd7 returns the prior contents (X, or 0 with `DATA_MEMORY_CLEAR_ON_RESET_EN`), not 0xAAAA5555.
- Change `address` from 6'd1 to 6'd2 during BUSY of a read of 6'd1 (preloaded 0x11111111, 6'd2 = 0x22222222): `readdata` = 0x11111111.
- Cache-style write-back then fill, with LATENCY=1 and LATENCY=5: `busywait` is low in DONE, the second request is accepted at E0+LATENCY+2, and the read returns the data just written.
